// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_write_reg,
  input  logic [DATA_W-1:0] exmem_alu_out,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_write_reg,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [2:0]        alu_select,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              load_use_stall
);
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic [2:0]        alu_control;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } idex_t;
  idex_t ex_q, ex_d, load, bubble;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  always_comb begin
    bubble = '0;
    bubble.alu_control = 3'b010;
    load.valid = id_valid;
    load.reg_write = id_valid & id_reg_write;
    load.mem_to_reg = id_valid & id_mem_to_reg;
    load.mem_write = id_valid & id_mem_write;
    load.alu_src = id_alu_src;
    load.alu_control = id_alu_control;
    load.rs = id_rs;
    load.rt = id_rt;
    load.write_reg = id_reg_dst ? id_rd : id_rt;
    load.rs_data = id_rs_data;
    load.rt_data = id_rt_data;
    load.imm = id_imm;
    load_use_stall = ex_q.valid & ex_q.mem_to_reg & (ex_q.write_reg != '0) & id_valid &
                     ((ex_q.write_reg == id_rs) | (ex_q.write_reg == id_rt));
    ex_d = flush ? bubble : stall ? ex_q : load_use_stall ? bubble : load;
    // Register 0 never forwards; EX/MEM is newer so it wins over MEM/WB.
    fwd_rs = (exmem_reg_write && exmem_write_reg == ex_q.rs && ex_q.rs != '0) ? exmem_alu_out :
             (memwb_reg_write && memwb_write_reg == ex_q.rs && ex_q.rs != '0) ? memwb_result :
             ex_q.rs_data;
    fwd_rt = (exmem_reg_write && exmem_write_reg == ex_q.rt && ex_q.rt != '0) ? exmem_alu_out :
             (memwb_reg_write && memwb_write_reg == ex_q.rt && ex_q.rt != '0) ? memwb_result :
             ex_q.rt_data;
    alu_select = ex_q.alu_control;
    alu_a = fwd_rs;
    alu_b = ex_q.alu_src ? ex_q.imm : fwd_rt;
    ex_store_data = fwd_rt;
    ex_write_reg = ex_q.write_reg;
    ex_valid = ex_q.valid;
    ex_reg_write = ex_q.reg_write;
    ex_mem_to_reg = ex_q.mem_to_reg;
    ex_mem_write = ex_q.mem_write;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ex_q <= '0;
    else ex_q <= ex_d;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan scenarios plus randomized traffic against a behavioural ID/EX model.
module tb_id_ex_stage;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [2:0] id_alu_control = '0;
  logic id_alu_src = 1'b0, id_reg_dst = 1'b0, id_reg_write = 1'b0, id_mem_to_reg = 1'b0, id_mem_write = 1'b0;
  logic exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0] exmem_write_reg = '0, memwb_write_reg = '0;
  logic [31:0] exmem_alu_out = '0, memwb_result = '0;
  logic [2:0] alu_select;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0] ex_write_reg;
  logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, load_use_stall;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_write_reg(exmem_write_reg), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_write_reg(memwb_write_reg), .memwb_result(memwb_result),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );
  typedef struct {
    bit v, rw, mr, mw, src;
    bit [2:0] op;
    bit [4:0] rs, rt, wr;
    bit [31:0] rsd, rtd, imm;
  } mstate_t;
  mstate_t m, n;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  function automatic mstate_t empty_slot(input bit [2:0] op);
    mstate_t s;
    s = '{v: 0, rw: 0, mr: 0, mw: 0, src: 0, op: op, rs: 0, rt: 0, wr: 0, rsd: 0, rtd: 0, imm: 0};
    return s;
  endfunction
  function automatic bit [31:0] fwd_m(input bit [4:0] r, input bit [31:0] d);
    if (r == 0) return d;
    if (exmem_reg_write && exmem_write_reg == r) return exmem_alu_out;
    if (memwb_reg_write && memwb_write_reg == r) return memwb_result;
    return d;
  endfunction
  function automatic bit hazard_m();
    return m.v && m.mr && m.wr != 0 && id_valid && (m.wr == id_rs || m.wr == id_rt);
  endfunction
  task automatic check_all();
    chk("alu_select", alu_select, m.op);
    chk("alu_a", alu_a, fwd_m(m.rs, m.rsd));
    chk("alu_b", alu_b, m.src ? m.imm : fwd_m(m.rt, m.rtd));
    chk("store_data", ex_store_data, fwd_m(m.rt, m.rtd));
    chk("write_reg", ex_write_reg, m.wr);
    chk("ctrl", {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write}, {m.v, m.rw, m.mr, m.mw});
    chk("load_use_stall", load_use_stall, hazard_m());
  endtask
  task automatic tick();
    #1;
    check_all();
    if (flush || (!stall && hazard_m())) n = empty_slot(3'b010);
    else if (stall) n = m;
    else begin
      n.v = id_valid; n.rw = id_valid && id_reg_write; n.mr = id_valid && id_mem_to_reg;
      n.mw = id_valid && id_mem_write; n.src = id_alu_src; n.op = id_alu_control;
      n.rs = id_rs; n.rt = id_rt; n.wr = id_reg_dst ? id_rd : id_rt;
      n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask
  task automatic set_id(input bit v, input bit [2:0] op, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit src, input bit dst, input bit rw, input bit mr, input bit mw);
    id_valid = v; id_alu_control = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = rw; id_mem_to_reg = mr; id_mem_write = mw;
  endtask
  bit [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  initial begin
    m = empty_slot(3'b000);
    #2;
    chk("reset_ctrl", {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write}, 4'b0);
    chk("reset_sel", alu_select, 3'b000);
    chk("reset_wr", ex_write_reg, 5'd0);
    reset = 1'b0;
    set_id(1, 3'b010, 1, 2, 3, 5, 7, 0, 0, 1, 1, 0, 0);
    tick();
    chk("add_sel", alu_select, 3'b010);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_valid", ex_valid, 1'b1);
    exmem_reg_write = 1; exmem_write_reg = 1; exmem_alu_out = 32'h20;
    memwb_reg_write = 1; memwb_write_reg = 1; memwb_result = 32'h10;
    #1 chk("fwd_exmem_prio", alu_a, 32'h20);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 32'h10);
    reset = 1'b1;
    #1;
    m = empty_slot(3'b000);
    chk("async_reset_valid", ex_valid, 1'b0);
    chk("async_reset_sel", alu_select, 3'b000);
    reset = 1'b0;
    memwb_reg_write = 0;
    set_id(1, 3'b010, 0, 2, 3, 0, 7, 0, 0, 1, 1, 0, 0);
    tick();
    exmem_reg_write = 1; exmem_write_reg = 0; exmem_alu_out = 32'hFFFF;
    #1 chk("no_fwd_r0", alu_a, 32'd0);
    exmem_reg_write = 0;
    set_id(1, 3'b010, 0, 3, 0, 0, 0, 4, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 3'b110, 3, 1, 5, 32'hDEAD, 9, 0, 0, 1, 1, 0, 0);
    #1 chk("lu_stall_hi", load_use_stall, 1'b1);
    tick();
    chk("bubble_valid", ex_valid, 1'b0);
    chk("bubble_rw", ex_reg_write, 1'b0);
    chk("bubble_sel", alu_select, 3'b010);
    memwb_reg_write = 1; memwb_write_reg = 3; memwb_result = 32'h33;
    tick();
    chk("sub_fwd_memwb", alu_a, 32'h33);
    chk("sub_sel", alu_select, 3'b110);
    memwb_reg_write = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, ops[$urandom_range(0, 4)], 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk("stall_sel", alu_select, 3'b110);
      chk("stall_wr", ex_write_reg, 5'd5);
    end
    flush = 1;
    tick();
    chk("flush_stall_valid", ex_valid, 1'b0);
    chk("flush_stall_sel", alu_select, 3'b010);
    stall = 0; flush = 0;
    set_id(1, 3'b010, 0, 4, 0, 0, 32'h55, 8, 1, 0, 0, 0, 1);
    tick();
    exmem_reg_write = 1; exmem_write_reg = 4; exmem_alu_out = 32'hAB;
    #1;
    chk("sw_b", alu_b, 32'd8);
    chk("sw_store", ex_store_data, 32'hAB);
    chk("sw_mw", ex_mem_write, 1'b1);
    exmem_reg_write = 0;
    set_id(1, 3'b010, 0, 2, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 3'b010, 2, 0, 6, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 chk("hazard_pre_reset", load_use_stall, 1'b1);
    reset = 1'b1;
    #1;
    m = empty_slot(3'b000);
    chk("hazard_reset_clear", load_use_stall, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 4) != 0, ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 7) == 0;
      exmem_reg_write = 1'($urandom); exmem_write_reg = 5'($urandom_range(0, 3)); exmem_alu_out = $urandom;
      memwb_reg_write = 1'($urandom); memwb_write_reg = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
